// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR command path.
// Holds the request command codes, the scheduler state encoding, the
// read/write direction type and the helpers that classify a command code.
package ddr_pkg;

  localparam logic [2:0] RD_R  = 3'b001;
  localparam logic [2:0] RDA_R = 3'b010;
  localparam logic [2:0] WR_R  = 3'b100;
  localparam logic [2:0] WRA_R = 3'b101;

  typedef enum logic [2:0] {
    SCH_IDLE = 3'd0,
    SCH_TURN = 3'd1,
    SCH_RD   = 3'd2,
    SCH_WR   = 3'd3,
    SCH_REF  = 3'd4
  } sched_state_t;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } dir_t;

  function automatic logic is_rd_cmd(input logic [2:0] cmd);
    return (cmd == RD_R) || (cmd == RDA_R);
  endfunction

  function automatic logic is_wr_cmd(input logic [2:0] cmd);
    return (cmd == WR_R) || (cmd == WRA_R);
  endfunction

endpackage

// File: rtl/ctrl_req_fifo.sv
// Request queue for the read/write scheduler.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   push, push_data       write an entry (ignored when full)
//   pop                   drop the head entry (ignored when empty)
//   head                  current head entry
//   full, empty, count    occupancy, count ranges 0..DEPTH
//   ent_valid, ent_data   per-slot valid flag and flattened slot contents,
//                         used by the scheduler for address hazard compares
module ctrl_req_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       ent_valid,
  output logic [DEPTH*W-1:0]     ent_data
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // A slot holds live data when its distance from the head is below count.
  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, AW'(AW'(i) - rd_ptr)} < count);
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    assign ent_data[g*W +: W] = mem[g];
  end

endmodule

// File: rtl/ctrl_rw_sched.sv
// Read/write request scheduler in front of the ACT/CAS timing controllers.
// Batches same-direction requests, inserts a turnaround gap on direction
// change, gives writes priority on a read-after-write address hazard or a
// high write backlog, and parks for refresh.
// Ports:
//   CK_t, reset                       clock, synchronous active-high reset
//   in_valid/in_ready/in_cmd/in_addr  incoming request handshake
//   out_valid/out_ready/out_cmd/out_addr  request handed to the ACT stage
//   turn_cycles                       idle gap on a direction change
//   ref_req/ref_gnt                   refresh request / scheduler parked
//   illegal_cmd                       pulse after an unsupported code
//   rd_cnt, wr_cnt                    queue occupancies
//   sched_idle                        idle, queues empty, nothing presented
//
// state    | meaning
// SCH_IDLE | pick the next direction or park for refresh
// SCH_TURN | turnaround gap before switching direction
// SCH_RD   | issuing read-queue heads
// SCH_WR   | issuing write-queue heads
// SCH_REF  | parked, refresh owns the command bus
module ctrl_rw_sched
  import ddr_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 8,
  parameter int WR_HI     = 6,
  parameter int MAX_BURST = 4
) (
  input  logic                   CK_t,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_cmd,
  input  logic [ADDR_W-1:0]      in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2:0]             out_cmd,
  output logic [ADDR_W-1:0]      out_addr,
  input  logic [7:0]             turn_cycles,
  input  logic                   ref_req,
  output logic                   ref_gnt,
  output logic                   illegal_cmd,
  output logic [$clog2(DEPTH):0] rd_cnt,
  output logic [$clog2(DEPTH):0] wr_cnt,
  output logic                   sched_idle
);

  localparam int CW = ADDR_W + 3;
  localparam int QW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  sched_state_t    state, state_nxt;
  dir_t            last_dir, turn_tgt, pick_dir;
  logic [BW-1:0]   burst_cnt;
  logic [7:0]      turn_cnt;

  logic            in_is_rd, in_is_wr;
  logic            rd_push, wr_push, rd_pop, wr_pop;
  logic [CW-1:0]   rd_head, wr_head;
  logic            rd_full, wr_full, rd_empty, wr_empty;
  logic [DEPTH-1:0]    rd_ent_valid, wr_ent_valid;
  logic [DEPTH*CW-1:0] rd_ent_data, wr_ent_data;
  logic            unused_rd_view;
  logic            raw_hazard, burst_max, wr_high, slot_free, rd_stop, wr_stop;

  assign in_is_rd = is_rd_cmd(in_cmd);
  assign in_is_wr = is_wr_cmd(in_cmd);
  assign in_ready = in_is_rd ? !rd_full : (in_is_wr ? !wr_full : 1'b1);
  assign rd_push  = in_valid && in_is_rd && !rd_full;
  assign wr_push  = in_valid && in_is_wr && !wr_full;

  ctrl_req_fifo #(.W(CW), .DEPTH(DEPTH)) u_rd_q (
    .clk(CK_t), .reset(reset), .push(rd_push), .push_data({in_cmd, in_addr}),
    .pop(rd_pop), .head(rd_head), .full(rd_full), .empty(rd_empty),
    .count(rd_cnt), .ent_valid(rd_ent_valid), .ent_data(rd_ent_data)
  );

  ctrl_req_fifo #(.W(CW), .DEPTH(DEPTH)) u_wr_q (
    .clk(CK_t), .reset(reset), .push(wr_push), .push_data({in_cmd, in_addr}),
    .pop(wr_pop), .head(wr_head), .full(wr_full), .empty(wr_empty),
    .count(wr_cnt), .ent_valid(wr_ent_valid), .ent_data(wr_ent_data)
  );

  // Only the write queue's slot view feeds the hazard compare.
  assign unused_rd_view = ^{rd_ent_valid, rd_ent_data};

  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!rd_empty && wr_ent_valid[i] &&
          (wr_ent_data[i*CW +: ADDR_W] == rd_head[ADDR_W-1:0])) begin
        raw_hazard = 1'b1;
      end
    end
  end

  assign burst_max = (burst_cnt == BW'(MAX_BURST));
  assign wr_high   = (wr_cnt >= QW'(WR_HI));
  assign slot_free = !out_valid || out_ready;
  assign rd_stop   = (burst_max && !wr_empty) || wr_high || raw_hazard || ref_req;
  assign wr_stop   = (burst_max && !rd_empty && !wr_high) || ref_req;

  // A read batch that ended on the burst limit hands over to waiting writes;
  // otherwise reads win unless writes are backed up, hazarded, or alone.
  assign pick_dir = (wr_high || rd_empty || raw_hazard ||
                     (last_dir == RD && burst_max && !wr_empty)) ? WR : RD;

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state     <= SCH_IDLE;
      last_dir  <= RD;
      burst_cnt <= '0;
      turn_cnt  <= '0;
      turn_tgt  <= RD;
    end else begin
      state <= state_nxt;
      if (state == SCH_IDLE && state_nxt == SCH_TURN) begin
        turn_cnt <= turn_cycles;
        turn_tgt <= pick_dir;
      end else if (state == SCH_TURN) begin
        turn_cnt <= turn_cnt - 8'd1;
      end
      if ((state_nxt == SCH_RD || state_nxt == SCH_WR) && state_nxt != state) begin
        burst_cnt <= '0;
        last_dir  <= (state_nxt == SCH_WR) ? WR : RD;
      end else if ((rd_pop || wr_pop) && !burst_max) begin
        // Holding at the limit keeps a long solo batch yielding as soon
        // as the other direction shows up.
        burst_cnt <= burst_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      SCH_IDLE: begin
        if (ref_req) begin
          // Wait for any presented request to be taken before parking.
          if (!out_valid) state_nxt = SCH_REF;
        end else if (!rd_empty || !wr_empty) begin
          if (pick_dir != last_dir && turn_cycles != 8'd0) state_nxt = SCH_TURN;
          else state_nxt = (pick_dir == WR) ? SCH_WR : SCH_RD;
        end
      end
      SCH_TURN: if (turn_cnt <= 8'd1) state_nxt = (turn_tgt == WR) ? SCH_WR : SCH_RD;
      SCH_RD:   if (slot_free && (rd_empty || rd_stop)) state_nxt = SCH_IDLE;
      SCH_WR:   if (slot_free && (wr_empty || wr_stop)) state_nxt = SCH_IDLE;
      SCH_REF:  if (!ref_req) state_nxt = SCH_IDLE;
      default:  state_nxt = SCH_IDLE;
    endcase
  end

  always_comb begin
    rd_pop     = (state == SCH_RD) && slot_free && !rd_empty && !rd_stop;
    wr_pop     = (state == SCH_WR) && slot_free && !wr_empty && !wr_stop;
    ref_gnt    = (state == SCH_REF) && ref_req;
    sched_idle = (state == SCH_IDLE) && rd_empty && wr_empty && !out_valid;
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_cmd     <= '0;
      out_addr    <= '0;
      illegal_cmd <= 1'b0;
    end else begin
      illegal_cmd <= in_valid && !in_is_rd && !in_is_wr;
      if (rd_pop) begin
        {out_cmd, out_addr} <= rd_head;
        out_valid           <= 1'b1;
      end else if (wr_pop) begin
        {out_cmd, out_addr} <= wr_head;
        out_valid           <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_rw_sched.sv
// Directed bench for ctrl_rw_sched with an in-order scoreboard of the
// requests expected at the ACT-stage handshake.
module tb_ctrl_rw_sched;
  import ddr_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;

  logic              CK_t = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_cmd = RD_R;
  logic [ADDR_W-1:0] in_addr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [2:0]        out_cmd;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        turn_cycles = 8'd0;
  logic              ref_req = 1'b0;
  logic              ref_gnt;
  logic              illegal_cmd;
  logic [3:0]        rd_cnt, wr_cnt;
  logic              sched_idle;

  ctrl_rw_sched #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WR_HI(6), .MAX_BURST(4)) dut (
    .CK_t(CK_t), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_addr(in_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_cmd(out_cmd), .out_addr(out_addr),
    .turn_cycles(turn_cycles), .ref_req(ref_req), .ref_gnt(ref_gnt),
    .illegal_cmd(illegal_cmd), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .sched_idle(sched_idle)
  );

  always #5 CK_t = ~CK_t;

  typedef struct {
    logic [2:0]        cmd;
    logic [ADDR_W-1:0] addr;
  } item_t;

  item_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_rd_hs = 0;
  int    last_wr_hs = 0;

  always @(posedge CK_t) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Handshake monitor: the request shown with out_ready high is taken at
  // the next rising edge.
  always @(negedge CK_t) begin
    item_t it;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_issue", 64'(exp_q.size()), 64'd1);
      end else begin
        it = exp_q.pop_front();
        chk("sb_cmd", 64'(out_cmd), 64'(it.cmd));
        chk("sb_addr", 64'(out_addr), 64'(it.addr));
      end
      if (is_rd_cmd(out_cmd)) last_rd_hs = cyc;
      else last_wr_hs = cyc;
    end
  end

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic push_req(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_addr  = addr;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_item(input logic [2:0] cmd, input logic [ADDR_W-1:0] addr);
    item_t it;
    it.cmd  = cmd;
    it.addr = addr;
    exp_q.push_back(it);
  endtask

  task automatic wait_ref_gnt(input logic want);
    for (int i = 0; i < 20 && ref_gnt !== want; i++) @(negedge CK_t);
    chk("ref_gnt_wait", 64'(ref_gnt), 64'(want));
  endtask

  task automatic wait_out_valid();
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge CK_t);
    chk("out_valid_wait", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge CK_t);
    chk(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset values
    tick(); tick();
    @(negedge CK_t);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_cmd", 64'(out_cmd), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_ref_gnt", 64'(ref_gnt), 64'd0);
    chk("rst_illegal", 64'(illegal_cmd), 64'd0);
    chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
    chk("rst_sched_idle", 64'(sched_idle), 64'd1);
    tick();
    reset = 1'b0;

    // Three reads: first valid two edges after accept, then back-to-back
    out_ready = 1'b1;
    expect_item(RD_R, 32'h10); expect_item(RD_R, 32'h20); expect_item(RD_R, 32'h30);
    push_req(RD_R, 32'h10);
    @(negedge CK_t); chk("lat_n1_valid", 64'(out_valid), 64'd0);
    push_req(RD_R, 32'h20);
    @(negedge CK_t); chk("lat_n2_valid", 64'(out_valid), 64'd0);
    push_req(RD_R, 32'h30);
    @(negedge CK_t); chk("lat_first_valid", 64'(out_valid), 64'd1);
    chk("lat_first_addr", 64'(out_addr), 64'h10);
    tick(); @(negedge CK_t); chk("b2b_addr2", 64'(out_addr), 64'h20);
    chk("b2b_valid2", 64'(out_valid), 64'd1);
    tick(); @(negedge CK_t); chk("b2b_addr3", 64'(out_addr), 64'h30);
    tick(); @(negedge CK_t); chk("b2b_done_valid", 64'(out_valid), 64'd0);
    tick(); @(negedge CK_t); chk("b2b_sched_idle", 64'(sched_idle), 64'd1);
    drain("drain_b2b", 10);

    // Read->write with a 5-cycle turnaround: the gap between the last read
    // and the write is the 2-cycle decide/pop pipeline plus turn_cycles.
    tick();
    turn_cycles = 8'd5;
    expect_item(RD_R, 32'hA0); expect_item(RDA_R, 32'hB0); expect_item(WR_R, 32'hC0);
    push_req(RD_R, 32'hA0);
    push_req(RDA_R, 32'hB0);
    push_req(WR_R, 32'hC0);
    drain("drain_turn5", 40);
    tick(); tick();
    chk("turn5_gap", 64'(last_wr_hs - last_rd_hs - 1), 64'd7);

    // Write->read with no turnaround: only the pipeline gap remains.
    turn_cycles = 8'd0;
    expect_item(WR_R, 32'hD0); expect_item(WRA_R, 32'hE0); expect_item(RD_R, 32'hF0);
    push_req(WR_R, 32'hD0);
    push_req(WRA_R, 32'hE0);
    push_req(RD_R, 32'hF0);
    drain("drain_turn0", 40);
    tick(); tick();
    chk("turn0_gap", 64'(last_rd_hs - last_wr_hs - 1), 64'd2);

    // RAW: a read to an address with a pending write waits for the write
    ref_req = 1'b1;
    wait_ref_gnt(1'b1);
    tick();
    expect_item(WR_R, 32'h40); expect_item(RD_R, 32'h40);
    push_req(WR_R, 32'h40);
    push_req(RD_R, 32'h40);
    ref_req = 1'b0;
    drain("drain_raw", 30);
    tick(); tick();

    // Batching: 6 writes (at the watermark) and 8 reads loaded while parked
    ref_req = 1'b1;
    wait_ref_gnt(1'b1);
    tick();
    for (int i = 0; i < 4; i++) expect_item((i % 2) ? WRA_R : WR_R, 32'h100 + 32'(4*i));
    for (int i = 0; i < 4; i++) expect_item((i % 2) ? RDA_R : RD_R, 32'h200 + 32'(4*i));
    for (int i = 4; i < 6; i++) expect_item((i % 2) ? WRA_R : WR_R, 32'h100 + 32'(4*i));
    for (int i = 4; i < 8; i++) expect_item((i % 2) ? RDA_R : RD_R, 32'h200 + 32'(4*i));
    for (int i = 0; i < 6; i++) push_req((i % 2) ? WRA_R : WR_R, 32'h100 + 32'(4*i));
    for (int i = 0; i < 8; i++) push_req((i % 2) ? RDA_R : RD_R, 32'h200 + 32'(4*i));
    @(negedge CK_t);
    chk("batch_wr_cnt", 64'(wr_cnt), 64'd6);
    chk("batch_rd_cnt", 64'(rd_cnt), 64'd8);
    chk("batch_parked_valid", 64'(out_valid), 64'd0);
    tick();
    ref_req = 1'b0;
    drain("drain_batch", 80);
    tick(); tick();

    // Stall with refresh pending: payload held, grant only after handshake
    out_ready = 1'b0;
    expect_item(RD_R, 32'h50); expect_item(RD_R, 32'h60);
    push_req(RD_R, 32'h50);
    push_req(RD_R, 32'h60);
    wait_out_valid();
    chk("stall_addr0", 64'(out_addr), 64'h50);
    tick();
    ref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CK_t);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_addr", 64'(out_addr), 64'h50);
      chk("stall_no_gnt", 64'(ref_gnt), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_ref_gnt(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("ref_no_pop_valid", 64'(out_valid), 64'd0);
      chk("ref_no_pop_rd_cnt", 64'(rd_cnt), 64'd1);
      tick(); @(negedge CK_t);
    end
    expect_item(WR_R, 32'h70);
    tick();
    push_req(WR_R, 32'h70);
    @(negedge CK_t);
    chk("ref_accept_wr_cnt", 64'(wr_cnt), 64'd1);
    chk("ref_gnt_held", 64'(ref_gnt), 64'd1);
    tick();
    ref_req = 1'b0;
    @(negedge CK_t);
    chk("ref_gnt_drop", 64'(ref_gnt), 64'd0);
    tick();
    out_ready = 1'b1;
    drain("drain_ref", 30);
    tick(); tick();

    // Full read queue, illegal code, then reset mid-burst
    ref_req = 1'b1;
    wait_ref_gnt(1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_item(RD_R, 32'h300 + 32'(4*i));
      push_req(RD_R, 32'h300 + 32'(4*i));
    end
    in_cmd = RD_R;
    @(negedge CK_t);
    chk("full_rd_cnt", 64'(rd_cnt), 64'd8);
    chk("full_rd_ready", 64'(in_ready), 64'd0);
    tick();
    in_cmd = WR_R;
    @(negedge CK_t);
    chk("full_wr_ready", 64'(in_ready), 64'd1);
    tick();
    push_req(RD_R, 32'h3F0);
    @(negedge CK_t);
    chk("full_blocked_rd_cnt", 64'(rd_cnt), 64'd8);
    tick();
    in_cmd = 3'b111;
    @(negedge CK_t);
    chk("illegal_ready", 64'(in_ready), 64'd1);
    tick();
    push_req(3'b111, 32'h3F4);
    @(negedge CK_t);
    chk("illegal_pulse", 64'(illegal_cmd), 64'd1);
    chk("illegal_rd_cnt", 64'(rd_cnt), 64'd8);
    chk("illegal_wr_cnt", 64'(wr_cnt), 64'd0);
    tick(); @(negedge CK_t);
    chk("illegal_pulse_end", 64'(illegal_cmd), 64'd0);
    tick();
    ref_req = 1'b0;
    wait_out_valid();
    tick();
    reset = 1'b1;
    tick();
    @(negedge CK_t);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rd_cnt", 64'(rd_cnt), 64'd0);
    chk("midrst_wr_cnt", 64'(wr_cnt), 64'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick(); @(negedge CK_t);
    chk("midrst_sched_idle", 64'(sched_idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
